// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 encodings for loads and
// stores, the access FSM state encoding, and write-back source selects.
package mem_pkg;

  // Load funct3
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2,
    S_HOLD   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering for the data-memory bus.
//   is_load_i / is_store_i : access kind (store wins if both are set)
//   funct3_i               : access size and sign
//   addr_i                 : byte offset within the word
//   rs2_i                  : store data
//   rdata_i                : raw bus read data
//   be_o / wdata_o         : store byte enables and lane-replicated data
//   ldata_o                : formatted (extended) load data, 0 for non-loads
//   fault_o                : misaligned access or illegal funct3
module load_store_align
  import mem_pkg::*;
(
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] rs2_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o,
  output logic        fault_o
);

  // Selected lane moved down to bit 0.
  logic [31:0] lane;
  assign lane = rdata_i >> {addr_i, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = 32'h0;
    ldata_o = 32'h0;
    fault_o = 1'b0;
    if (is_store_i) begin
      fault_o = funct3_i[2];
      case (funct3_i[1:0])
        2'b00: begin
          be_o    = 4'b0001 << addr_i;
          wdata_o = {4{rs2_i[7:0]}};
        end
        2'b01: begin
          be_o    = 4'b0011 << {addr_i[1], 1'b0};
          wdata_o = {2{rs2_i[15:0]}};
          fault_o = fault_o | addr_i[0];
        end
        default: begin
          be_o    = 4'b1111;
          wdata_o = rs2_i;
          fault_o = fault_o | (|addr_i);
        end
      endcase
    end else if (is_load_i) begin
      case (funct3_i)
        F3_LB:  ldata_o = {{24{lane[7]}}, lane[7:0]};
        F3_LBU: ldata_o = {24'h0, lane[7:0]};
        F3_LH: begin
          ldata_o = {{16{lane[15]}}, lane[15:0]};
          fault_o = addr_i[0];
        end
        F3_LHU: begin
          ldata_o = {16'h0, lane[15:0]};
          fault_o = addr_i[0];
        end
        F3_LW: begin
          ldata_o = rdata_i;
          fault_o = |addr_i;
        end
        default: fault_o = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM stage of the RV32 pipeline: runs one req/ack bus access per memory
// instruction in EX/MEM, freezes the front of the pipeline while it is
// outstanding, and drives the MEM/WB register.
//   clk_i, rst_i             : clock, synchronous active-high reset
//   *_i (EX/MEM fields)      : instruction in the EX/MEM register
//   ex_stall_i               : MDU stall, EX/MEM held
//   mem_*                    : data-memory bus (registered request side)
//   busywait_o               : freeze IF/ID/EX and EX/MEM
//   addr_fault_o, bus_err_o  : one-cycle fault pulses
//   *_mem_wb_o               : MEM/WB register
module memory_access_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_W           = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        is_load_instr_i,
  input  logic        is_store_instr_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [4:0]  rd_i,
  input  logic        reg_wb_en_i,
  input  logic [1:0]  wb_sel_i,
  input  logic        ex_stall_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        busywait_o,
  output logic        addr_fault_o,
  output logic        bus_err_o,
  output logic [31:0] rd_data_mem_wb_o,
  output logic [31:0] alu_out_mem_wb_o,
  output logic [4:0]  rd_mem_wb_o,
  output logic        reg_wb_en_mem_wb_o,
  output logic [1:0]  wb_sel_mem_wb_o,
  output logic        is_memory_instruction_mem_wb_o
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  mem_state_e      state_q;
  logic [TO_W-1:0] to_cnt_q;
  logic [31:0]     hold_q;
  // Sticky outcome of the current instruction; kept through DONE/HOLD so
  // MEM/WB recaptures the same squashed write enable while stalled.
  logic            fault_q;
  logic            err_q;

  logic        mem_op;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] ldata;
  logic        fault;

  assign mem_op = is_load_instr_i | is_store_instr_i;

  // EX/MEM is frozen during ACCESS, so the live fields still describe the
  // access and can format the returning read data.
  load_store_align u_align (
    .is_load_i  (is_load_instr_i),
    .is_store_i (is_store_instr_i),
    .funct3_i   (funct3_i),
    .addr_i     (alu_out_i[1:0]),
    .rs2_i      (rs2_i),
    .rdata_i    (mem_rdata_i),
    .be_o       (be),
    .wdata_o    (wdata),
    .ldata_o    (ldata),
    .fault_o    (fault)
  );

  assign busywait_o = (state_q == S_ACCESS) || ((state_q == S_IDLE) && mem_op);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q                        <= S_IDLE;
      to_cnt_q                       <= '0;
      hold_q                         <= 32'h0;
      fault_q                        <= 1'b0;
      err_q                          <= 1'b0;
      mem_req_o                      <= 1'b0;
      mem_we_o                       <= 1'b0;
      mem_addr_o                     <= 32'h0;
      mem_wdata_o                    <= 32'h0;
      mem_be_o                       <= 4'b0000;
      addr_fault_o                   <= 1'b0;
      bus_err_o                      <= 1'b0;
      rd_data_mem_wb_o               <= 32'h0;
      alu_out_mem_wb_o               <= 32'h0;
      rd_mem_wb_o                    <= 5'd0;
      reg_wb_en_mem_wb_o             <= 1'b0;
      wb_sel_mem_wb_o                <= 2'd0;
      is_memory_instruction_mem_wb_o <= 1'b0;
    end else begin
      addr_fault_o <= 1'b0;
      bus_err_o    <= 1'b0;

      if (!busywait_o) begin
        rd_data_mem_wb_o               <= hold_q;
        alu_out_mem_wb_o               <= alu_out_i;
        rd_mem_wb_o                    <= rd_i;
        reg_wb_en_mem_wb_o             <= reg_wb_en_i & ~((fault_q | err_q) & is_load_instr_i);
        wb_sel_mem_wb_o                <= wb_sel_i;
        is_memory_instruction_mem_wb_o <= is_load_instr_i;
      end

      case (state_q)
        S_IDLE: begin
          if (mem_op) begin
            if (fault) begin
              fault_q      <= 1'b1;
              addr_fault_o <= 1'b1;
              hold_q       <= 32'h0;
              state_q      <= S_DONE;
            end else begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= is_store_instr_i;
              mem_addr_o  <= {alu_out_i[31:2], 2'b00};
              mem_be_o    <= be;
              mem_wdata_o <= wdata;
              to_cnt_q    <= '0;
              state_q     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem_ack_i) begin
            hold_q    <= ldata;
            mem_req_o <= 1'b0;
            state_q   <= S_DONE;
          end else if (to_cnt_q == TO_LAST) begin
            hold_q    <= 32'h0;
            mem_req_o <= 1'b0;
            err_q     <= 1'b1;
            bus_err_o <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          if (ex_stall_i) begin
            state_q <= S_HOLD;
          end else begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        S_HOLD: begin
          if (!ex_stall_i) begin
            fault_q <= 1'b0;
            err_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
module tb_memory_access_stage;
  import mem_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        is_load_instr_i, is_store_instr_i;
  logic [31:0] alu_out_i, rs2_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        reg_wb_en_i;
  logic [1:0]  wb_sel_i;
  logic        ex_stall_i;
  logic        mem_req_o, mem_we_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_rdata_i;
  logic        mem_ack_i;
  logic        busywait_o, addr_fault_o, bus_err_o;
  logic [31:0] rd_data_mem_wb_o, alu_out_mem_wb_o;
  logic [4:0]  rd_mem_wb_o;
  logic        reg_wb_en_mem_wb_o;
  logic [1:0]  wb_sel_mem_wb_o;
  logic        is_memory_instruction_mem_wb_o;

  memory_access_stage #(.TIMEOUT_CYCLES(4), .TO_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .is_load_instr_i(is_load_instr_i), .is_store_instr_i(is_store_instr_i),
    .alu_out_i(alu_out_i), .rs2_i(rs2_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .reg_wb_en_i(reg_wb_en_i), .wb_sel_i(wb_sel_i), .ex_stall_i(ex_stall_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .busywait_o(busywait_o), .addr_fault_o(addr_fault_o), .bus_err_o(bus_err_o),
    .rd_data_mem_wb_o(rd_data_mem_wb_o), .alu_out_mem_wb_o(alu_out_mem_wb_o),
    .rd_mem_wb_o(rd_mem_wb_o), .reg_wb_en_mem_wb_o(reg_wb_en_mem_wb_o),
    .wb_sel_mem_wb_o(wb_sel_mem_wb_o),
    .is_memory_instruction_mem_wb_o(is_memory_instruction_mem_wb_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    is_load_instr_i  = 1'b0;
    is_store_instr_i = 1'b0;
    funct3_i         = 3'b000;
    rs2_i            = 32'h0;
    reg_wb_en_i      = 1'b0;
    wb_sel_i         = WB_ALU;
    mem_ack_i        = 1'b0;
  endtask

  typedef struct {
    string       nm;
    logic        ld, st;
    logic [2:0]  f3;
    logic [31:0] addr, rs2, rdata;
    int          ack_at;   // ACCESS cycle carrying the ack, 0 = never
    int          bw, req;  // expected busywait / mem_req_o cycles
    logic [3:0]  be;
    logic [31:0] wd, maddr, ldata;
    logic        fault, err, wben;
  } vec_t;

  vec_t vt[14];

  // Apply one memory op from IDLE through DONE and the MEM/WB capture.
  task automatic run_op(input vec_t v, input logic [4:0] rd);
    int bw, req, n;
    is_load_instr_i  = v.ld;
    is_store_instr_i = v.st;
    funct3_i         = v.f3;
    alu_out_i        = v.addr;
    rs2_i            = v.rs2;
    mem_rdata_i      = v.rdata;
    rd_i             = rd;
    reg_wb_en_i      = v.ld;
    wb_sel_i         = v.ld ? WB_MEM : WB_ALU;
    ex_stall_i       = 1'b0;
    mem_ack_i        = 1'b0;
    #1;
    bw = 0; req = 0; n = 0;
    while (busywait_o && n < 40) begin
      bw++;
      if (mem_req_o) begin
        req++;
        mem_ack_i = (req == v.ack_at);
      end
      tick();
      mem_ack_i = 1'b0;
      n++;
    end
    if (n >= 40) begin
      total++; bad++;
      $display("FAIL %s busywait bound: still high after %0d cycles", v.nm, n);
    end
    // DONE cycle
    chk({v.nm, " busywait cycles"}, bw, v.bw);
    chk({v.nm, " req cycles"}, req, v.req);
    chk({v.nm, " req low in DONE"}, {31'h0, mem_req_o}, 32'h0);
    chk({v.nm, " addr_fault"}, {31'h0, addr_fault_o}, {31'h0, v.fault});
    chk({v.nm, " bus_err"}, {31'h0, bus_err_o}, {31'h0, v.err});
    if (v.req > 0) begin
      chk({v.nm, " addr"}, mem_addr_o, v.maddr);
      chk({v.nm, " we"}, {31'h0, mem_we_o}, {31'h0, v.st});
      if (v.st) begin
        chk({v.nm, " be"}, {28'h0, mem_be_o}, {28'h0, v.be});
        chk({v.nm, " wdata"}, mem_wdata_o, v.wd);
      end
    end
    tick();
    idle_inputs();
    #1;
    chk({v.nm, " wb data"}, rd_data_mem_wb_o, v.ldata);
    chk({v.nm, " wb en"}, {31'h0, reg_wb_en_mem_wb_o}, {31'h0, v.wben});
    chk({v.nm, " wb rd"}, {27'h0, rd_mem_wb_o}, {27'h0, rd});
    chk({v.nm, " wb is_mem"}, {31'h0, is_memory_instruction_mem_wb_o}, {31'h0, v.ld});
    chk({v.nm, " pulses cleared"}, {30'h0, addr_fault_o, bus_err_o}, 32'h0);
  endtask

  initial begin
    int req_seen;
    vt[0]  = '{"SW",       0,1,F3_SW, 32'h100,32'hDEADBEEF,32'h0,        2,3,2,4'hF,32'hDEADBEEF,32'h100,32'h0,       0,0,0};
    vt[1]  = '{"LB",       1,0,F3_LB, 32'h103,32'h0,       32'h80FF1234, 1,2,1,4'h0,32'h0,       32'h100,32'hFFFFFF80,0,0,1};
    vt[2]  = '{"LBU",      1,0,F3_LBU,32'h103,32'h0,       32'h80FF1234, 1,2,1,4'h0,32'h0,       32'h100,32'h00000080,0,0,1};
    vt[3]  = '{"LHU",      1,0,F3_LHU,32'h102,32'h0,       32'h80FF1234, 1,2,1,4'h0,32'h0,       32'h100,32'h000080FF,0,0,1};
    vt[4]  = '{"LH",       1,0,F3_LH, 32'h102,32'h0,       32'h80FF1234, 1,2,1,4'h0,32'h0,       32'h100,32'hFFFF80FF,0,0,1};
    vt[5]  = '{"LW",       1,0,F3_LW, 32'h104,32'h0,       32'h12345678, 3,4,3,4'h0,32'h0,       32'h104,32'h12345678,0,0,1};
    vt[6]  = '{"SH",       0,1,F3_SH, 32'h102,32'h0000ABCD,32'h0,        1,2,1,4'hC,32'hABCDABCD,32'h100,32'h0,       0,0,0};
    vt[7]  = '{"SB",       0,1,F3_SB, 32'h101,32'h123456A5,32'h0,        1,2,1,4'h2,32'hA5A5A5A5,32'h100,32'h0,       0,0,0};
    vt[8]  = '{"LW mis",   1,0,F3_LW, 32'h101,32'h0,       32'h11111111, 0,1,0,4'h0,32'h0,       32'h0,  32'h0,       1,0,0};
    vt[9]  = '{"LH mis",   1,0,F3_LH, 32'h103,32'h0,       32'h11111111, 0,1,0,4'h0,32'h0,       32'h0,  32'h0,       1,0,0};
    vt[10] = '{"ST f3 100",0,1,3'b100,32'h100,32'h0,       32'h0,        0,1,0,4'h0,32'h0,       32'h0,  32'h0,       1,0,0};
    vt[11] = '{"LD f3 011",1,0,3'b011,32'h100,32'h0,       32'h11111111, 0,1,0,4'h0,32'h0,       32'h0,  32'h0,       1,0,0};
    vt[12] = '{"LB pos",   1,0,F3_LB, 32'h100,32'h0,       32'h0000007F, 1,2,1,4'h0,32'h0,       32'h100,32'h0000007F,0,0,1};
    vt[13] = '{"LW tmo",   1,0,F3_LW, 32'h108,32'h0,       32'hCAFEF00D, 0,5,4,4'h0,32'h0,       32'h108,32'h0,       0,1,0};

    idle_inputs();
    alu_out_i   = 32'h0;
    rd_i        = 5'd0;
    ex_stall_i  = 1'b0;
    mem_rdata_i = 32'h0;
    rst_i       = 1'b1;
    tick(); tick();
    rst_i = 1'b0;
    #1;
    chk("reset req", {31'h0, mem_req_o}, 32'h0);
    chk("reset busywait", {31'h0, busywait_o}, 32'h0);
    chk("reset wb fields", {rd_data_mem_wb_o[15:0], alu_out_mem_wb_o[7:0], 3'h0, rd_mem_wb_o},
        32'h0);

    // Non-memory op: no freeze, MEM/WB one cycle later.
    alu_out_i = 32'h55AA_1234; rd_i = 5'd3; reg_wb_en_i = 1'b1; wb_sel_i = WB_PC4;
    #1;
    chk("alu busywait", {31'h0, busywait_o}, 32'h0);
    tick();
    chk("alu wb alu_out", alu_out_mem_wb_o, 32'h55AA_1234);
    chk("alu wb rd", {27'h0, rd_mem_wb_o}, 32'd3);
    chk("alu wb sel", {30'h0, wb_sel_mem_wb_o}, {30'h0, WB_PC4});
    chk("alu wb en", {31'h0, reg_wb_en_mem_wb_o}, 32'h1);

    for (int i = 0; i < 14; i++) run_op(vt[i], 5'(i + 1));

    // Stray ack after the timeout is ignored.
    mem_rdata_i = 32'hFFFF_FFFF;
    mem_ack_i   = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    tick();
    chk("stray ack req", {31'h0, mem_req_o}, 32'h0);
    chk("stray ack busywait", {31'h0, busywait_o}, 32'h0);
    chk("stray ack bus_err", {31'h0, bus_err_o}, 32'h0);
    chk("stray ack wb data", rd_data_mem_wb_o, 32'h0);

    // SB with ex_stall held across DONE: one write, parked in HOLD.
    is_store_instr_i = 1'b1; funct3_i = F3_SB; alu_out_i = 32'h202; rs2_i = 32'h5A;
    rd_i = 5'd0; reg_wb_en_i = 1'b0; mem_ack_i = 1'b0;
    #1;
    req_seen = 0;
    for (int c = 0; c < 10 && busywait_o; c++) begin
      if (mem_req_o) begin req_seen++; mem_ack_i = 1'b1; end
      tick();
      mem_ack_i = 1'b0;
    end
    chk("hold be", {28'h0, mem_be_o}, 32'h4);
    chk("hold wdata", mem_wdata_o, 32'h5A5A5A5A);
    ex_stall_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (mem_req_o) req_seen++;
      if (busywait_o) begin
        total++; bad++;
        $display("FAIL hold busywait: got 1 want 0 at stall cycle %0d", c);
      end
    end
    ex_stall_i = 1'b0;
    tick();
    idle_inputs();
    #1;
    chk("hold no reissue", {31'h0, mem_req_o}, 32'h0);
    tick();
    if (mem_req_o) req_seen++;
    chk("hold write count", req_seen, 32'd1);

    // Reset in the middle of ACCESS.
    is_load_instr_i = 1'b1; funct3_i = F3_LW; alu_out_i = 32'h300; rd_i = 5'd9;
    reg_wb_en_i = 1'b1; wb_sel_i = WB_MEM;
    tick();
    chk("mid-access req up", {31'h0, mem_req_o}, 32'h1);
    rst_i = 1'b1;
    tick();
    idle_inputs();
    rst_i = 1'b0;
    #1;
    chk("rst req", {31'h0, mem_req_o}, 32'h0);
    chk("rst bus regs", mem_addr_o | mem_wdata_o | {28'h0, mem_be_o} | {31'h0, mem_we_o}, 32'h0);
    chk("rst wb regs", rd_data_mem_wb_o | alu_out_mem_wb_o | {27'h0, rd_mem_wb_o}
        | {30'h0, wb_sel_mem_wb_o} | {31'h0, reg_wb_en_mem_wb_o}
        | {31'h0, is_memory_instruction_mem_wb_o}, 32'h0);
    chk("rst pulses", {30'h0, addr_fault_o, bus_err_o}, 32'h0);
    chk("rst busywait", {31'h0, busywait_o}, 32'h0);
    tick();
    chk("rst no fault later", {29'h0, addr_fault_o, bus_err_o, mem_req_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
